ask_demod_ctrl: RTL and testbench

- Acquisition/lock controller for the ASK demodulator.
- Watches the thresholded envelope (env_high) at sample-clock rate and measures the shortest run between envelope edges. From that run it classifies the bit rate (6/8/10 kbps).
- Configures the demodulator's samples-per-bit, enables it, and issues per-edge bit re-sync pulses while locked.
- Drops lock on signal loss and re-acquires.

---
 rtl/ask_demod_ctrl_if.sv | 38 +++
 rtl/ask_demod_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_ask_demod_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ask_demod_ctrl_if.sv
// Host/demodulator-facing bundle of the ASK acquisition/lock controller.
// master: host side (drives enable and the thresholded envelope).
// slave : controller side (drives lock status and demodulator configuration).
interface ask_demod_ctrl_if;
    localparam int unsigned SPB_W  = 14;
    localparam int unsigned RATE_W = 4;

    logic              en;
    logic              env_high;
    logic              demod_en;
    logic [SPB_W-1:0]  spb;
    logic [RATE_W-1:0] rate_kbps;
    logic              locked;
    logic              sync_pulse;
    logic              err_pulse;

    modport master (
        output en,
        output env_high,
        input  demod_en,
        input  spb,
        input  rate_kbps,
        input  locked,
        input  sync_pulse,
        input  err_pulse
    );

    modport slave (
        input  en,
        input  env_high,
        output demod_en,
        output spb,
        output rate_kbps,
        output locked,
        output sync_pulse,
        output err_pulse
    );
endinterface

// File: rtl/ask_demod_ctrl.sv
// ASK demodulator acquisition/lock controller.
// Measures the shortest envelope run over MIN_EDGES runs, classifies the
// bit rate (6/8/10 kbps), configures and enables the demodulator, and emits
// one re-sync pulse per accepted edge while locked. Drops lock after
// LOSS_CYC cycles without an edge and re-acquires.
// Optional build macro ASK_DEMOD_CTRL_GLITCH_EN: adds a 3-sample persistence
// filter on env_high (edge latency 3 cycles instead of 1).
module ask_demod_ctrl #(
    parameter int unsigned SPB_6K    = 5000,
    parameter int unsigned SPB_8K    = 3750,
    parameter int unsigned SPB_10K   = 3000,
    parameter int unsigned TOL       = 200,
    parameter int unsigned MIN_EDGES = 8,
    parameter int unsigned LOSS_CYC  = 150000,
    parameter int unsigned CNT_W     = 18
) (
    input  logic            clk,
    input  logic            rst,
    ask_demod_ctrl_if.slave bus
);
    localparam int unsigned SPB_W  = 14;
    localparam int unsigned RATE_W = 4;
    localparam int unsigned EC_W   = $clog2(MIN_EDGES + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACQ      = 2'd1;
    localparam logic [1:0] ST_CLASSIFY = 2'd2;
    localparam logic [1:0] ST_LOCKED   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LOSS_TH  = CNT_W'(LOSS_CYC);
    localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] SPB10_C  = CNT_W'(SPB_10K);
    localparam logic [CNT_W-1:0] SPB8_C   = CNT_W'(SPB_8K);
    localparam logic [CNT_W-1:0] SPB6_C   = CNT_W'(SPB_6K);
    localparam logic [EC_W-1:0]  EDGES_C  = EC_W'(MIN_EDGES);

    // |run - ref_v| <= TOL without ever forming a negative difference
    function automatic logic within_tol(input logic [CNT_W-1:0] run,
                                        input logic [CNT_W-1:0] ref_v);
        logic [CNT_W-1:0] diff;
        diff = (run >= ref_v) ? (run - ref_v) : (ref_v - run);
        return (diff <= TOL_C);
    endfunction

    logic               edge_c;
    logic               timeout_c;
    logic               glitch_c;
    logic [CNT_W-1:0]   spb_ext_c;
    logic [CNT_W-1:0]   spb_lo_c;
    logic [CNT_W-1:0]   run_inc_c;
    logic [EC_W-1:0]    edge_inc_c;

    logic [1:0]         state_q,      state_d;
    logic [CNT_W-1:0]   run_cnt_q,    run_cnt_d;
    logic [CNT_W-1:0]   min_run_q,    min_run_d;
    logic [EC_W-1:0]    edge_cnt_q,   edge_cnt_d;
    logic               first_seen_q, first_seen_d;
    logic [SPB_W-1:0]   spb_q,        spb_d;
    logic [RATE_W-1:0]  rate_q,       rate_d;
    logic               locked_q,     locked_d;
    logic               demod_en_q,   demod_en_d;
    logic               sync_q,       sync_d;
    logic               err_q,        err_d;

`ifdef ASK_DEMOD_CTRL_GLITCH_EN
    logic [1:0] hist_q;
    logic       filt_q;

    // Filtered level moves only after three consecutive equal samples
    assign edge_c = (bus.env_high == hist_q[0]) && (bus.env_high == hist_q[1]) &&
                    (bus.env_high != filt_q);

    // Sample history and filtered envelope level
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], bus.env_high};
            if (edge_c) begin
                filt_q <= bus.env_high;
            end
        end
    end
`else
    logic env_q;

    assign edge_c = bus.env_high ^ env_q;

    // Previous envelope sample for raw edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            env_q <= 1'b0;
        end else begin
            env_q <= bus.env_high;
        end
    end
`endif

    assign timeout_c  = (run_cnt_q >= LOSS_TH);
    assign run_inc_c  = (run_cnt_q == CNT_MAX) ? run_cnt_q : (run_cnt_q + CNT_W'(1));
    assign edge_inc_c = edge_cnt_q + EC_W'(1);
    assign spb_ext_c  = CNT_W'(spb_q);
    assign spb_lo_c   = (spb_ext_c > TOL_C) ? (spb_ext_c - TOL_C) : '0;
    assign glitch_c   = (run_cnt_q < spb_lo_c);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            run_cnt_q    <= '0;
            min_run_q    <= '1;
            edge_cnt_q   <= '0;
            first_seen_q <= 1'b0;
            spb_q        <= '0;
            rate_q       <= '0;
            locked_q     <= 1'b0;
            demod_en_q   <= 1'b0;
            sync_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            min_run_q    <= min_run_d;
            edge_cnt_q   <= edge_cnt_d;
            first_seen_q <= first_seen_d;
            spb_q        <= spb_d;
            rate_q       <= rate_d;
            locked_q     <= locked_d;
            demod_en_q   <= demod_en_d;
            sync_q       <= sync_d;
            err_q        <= err_d;
        end
    end

    // Next-state, run measurement and classification
    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        min_run_d    = min_run_q;
        edge_cnt_d   = edge_cnt_q;
        first_seen_d = first_seen_q;
        spb_d        = spb_q;
        rate_d       = rate_q;
        locked_d     = locked_q;
        demod_en_d   = demod_en_q;
        sync_d       = 1'b0;
        err_d        = 1'b0;

        if (!bus.en) begin
            state_d      = ST_IDLE;
            run_cnt_d    = '0;
            min_run_d    = '1;
            edge_cnt_d   = '0;
            first_seen_d = 1'b0;
            spb_d        = '0;
            rate_d       = '0;
            locked_d     = 1'b0;
            demod_en_d   = 1'b0;
        end else begin
            if (state_q != ST_IDLE) begin
                run_cnt_d = run_inc_c;
            end

            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_ACQ;
                    run_cnt_d    = '0;
                    min_run_d    = '1;
                    edge_cnt_d   = '0;
                    first_seen_d = 1'b0;
                end

                ST_ACQ: begin
                    if (edge_c) begin
                        run_cnt_d = CNT_W'(1);
                        if (!first_seen_q) begin
                            first_seen_d = 1'b1;
                        end else begin
                            min_run_d  = (run_cnt_q < min_run_q) ? run_cnt_q : min_run_q;
                            edge_cnt_d = edge_inc_c;
                            if (edge_inc_c == EDGES_C) begin
                                state_d = ST_CLASSIFY;
                            end
                        end
                    end else if (timeout_c) begin
                        first_seen_d = 1'b0;
                        edge_cnt_d   = '0;
                        min_run_d    = '1;
                    end
                end

                ST_CLASSIFY: begin
                    if (edge_c) begin
                        run_cnt_d = CNT_W'(1);
                    end
                    if (within_tol(min_run_q, SPB10_C)) begin
                        state_d    = ST_LOCKED;
                        spb_d      = SPB_W'(SPB_10K);
                        rate_d     = RATE_W'(10);
                        locked_d   = 1'b1;
                        demod_en_d = 1'b1;
                    end else if (within_tol(min_run_q, SPB8_C)) begin
                        state_d    = ST_LOCKED;
                        spb_d      = SPB_W'(SPB_8K);
                        rate_d     = RATE_W'(8);
                        locked_d   = 1'b1;
                        demod_en_d = 1'b1;
                    end else if (within_tol(min_run_q, SPB6_C)) begin
                        state_d    = ST_LOCKED;
                        spb_d      = SPB_W'(SPB_6K);
                        rate_d     = RATE_W'(6);
                        locked_d   = 1'b1;
                        demod_en_d = 1'b1;
                    end else begin
                        // Keep first_seen: the run ending at the next edge is already timed
                        err_d      = 1'b1;
                        state_d    = ST_ACQ;
                        edge_cnt_d = '0;
                        min_run_d  = '1;
                        if (edge_c) begin
                            min_run_d  = run_cnt_q;
                            edge_cnt_d = EC_W'(1);
                        end
                    end
                end

                ST_LOCKED: begin
                    if (edge_c && !glitch_c) begin
                        run_cnt_d = CNT_W'(1);
                        sync_d    = 1'b1;
                    end else if (!edge_c && timeout_c) begin
                        // spb stays valid so the demodulator never sees 0 mid-bit
                        state_d      = ST_ACQ;
                        locked_d     = 1'b0;
                        demod_en_d   = 1'b0;
                        rate_d       = '0;
                        first_seen_d = 1'b0;
                        edge_cnt_d   = '0;
                        min_run_d    = '1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.demod_en   = demod_en_q;
    assign bus.spb        = spb_q;
    assign bus.rate_kbps  = rate_q;
    assign bus.locked     = locked_q;
    assign bus.sync_pulse = sync_q;
    assign bus.err_pulse  = err_q;

endmodule

// File: tb/tb_ask_demod_ctrl.sv
// Testbench for ask_demod_ctrl with time-scaled parameters (1/25 of nominal
// samples-per-bit and tolerance, short loss timeout) to keep runs short.
module tb_ask_demod_ctrl;
    localparam int P6    = 200;
    localparam int P8    = 150;
    localparam int P10   = 120;
    localparam int PTOL  = 8;
    localparam int PLOSS = 1500;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ask_demod_ctrl_if bus ();

    ask_demod_ctrl #(
        .SPB_6K    (P6),
        .SPB_8K    (P8),
        .SPB_10K   (P10),
        .TOL       (PTOL),
        .MIN_EDGES (8),
        .LOSS_CYC  (PLOSS),
        .CNT_W     (18)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks     = 0;
    int failures   = 0;
    int sync_total = 0;
    int err_total  = 0;
    int runs_q[$];

    typedef struct {
        int base;
        int pat;
        int nruns;
        int rate;
        int spb;
        int errs;
        int syncs;
    } vec_t;

    vec_t vecs[11];

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.sync_pulse === 1'b1) sync_total++;
        if (bus.err_pulse === 1'b1) err_total++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle();
        bus.env_high = ~bus.env_high;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int lk, input int rate, input int spbv);
        chk({tag, ".locked"},   32'(bus.locked),    lk);
        chk({tag, ".demod_en"}, 32'(bus.demod_en),  lk);
        chk({tag, ".rate"},     32'(bus.rate_kbps), rate);
        chk({tag, ".spb"},      32'(bus.spb),       spbv);
    endtask

    task automatic restart();
        bus.en = 1'b0;
        cyc(3);
        bus.en = 1'b1;
        cyc(4);
    endtask

    // One edge, then an edge after each run in runs_q
    task automatic play_runs();
        toggle();
        foreach (runs_q[i]) begin
            cyc(runs_q[i]);
            toggle();
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic int rate_of(input int mn);
        if (absd(mn, P10) <= PTOL) return 10;
        if (absd(mn, P8) <= PTOL) return 8;
        if (absd(mn, P6) <= PTOL) return 6;
        return 0;
    endfunction

    function automatic int spb_of(input int rate);
        return (rate == 10) ? P10 : (rate == 8) ? P8 : P6;
    endfunction

    // Run-level reference: classify after every 8 measured runs, then count
    // accepted runs (glitch runs merge into the following run)
    task automatic model(output int lk, output int rate, output int spbv,
                         output int errs, output int syncs);
        int cnt;
        int mn;
        int acc;
        lk = 0; rate = 0; spbv = 0; errs = 0; syncs = 0;
        cnt = 0; mn = 32'h7fffffff; acc = 0;
        foreach (runs_q[i]) begin
            if (lk == 0) begin
                if (runs_q[i] < mn) mn = runs_q[i];
                cnt++;
                if (cnt == 8) begin
                    rate = rate_of(mn);
                    if (rate != 0) begin
                        lk = 1;
                        spbv = spb_of(rate);
                    end else begin
                        errs++;
                    end
                    cnt = 0;
                    mn = 32'h7fffffff;
                end
            end else begin
                acc += runs_q[i];
                if (acc >= spbv - PTOL) begin
                    syncs++;
                    acc = 0;
                end
            end
        end
    endtask

    task automatic run_and_check(input string tag, input int lk, input int rate,
                                 input int spbv, input int errs, input int syncs);
        int s0;
        int e0;
        s0 = sync_total;
        e0 = err_total;
        play_runs();
        cyc(8);
        chk_outs(tag, lk, rate, spbv);
        chk({tag, ".errs"},  32'(err_total - e0),  errs);
        chk({tag, ".syncs"}, 32'(sync_total - s0), syncs);
    endtask

    task automatic fill_square(input int base, input int n);
        runs_q.delete();
        for (int i = 0; i < n; i++) runs_q.push_back(base);
    endtask

    initial begin
        int s0;
        int m_lk, m_rate, m_spb, m_errs, m_syncs;

        // base, pattern(1:2:3), runs, rate, spb, errs, syncs
        vecs[0]  = '{200, 0, 11,  6, 200, 0, 3};
        vecs[1]  = '{150, 0, 11,  8, 150, 0, 3};
        vecs[2]  = '{120, 1, 11, 10, 120, 0, 3};
        vecs[3]  = '{176, 0, 16,  0,   0, 2, 0};
        vecs[4]  = '{208, 0, 10,  6, 200, 0, 2};
        vecs[5]  = '{209, 0, 10,  0,   0, 1, 0};
        vecs[6]  = '{192, 0, 10,  6, 200, 0, 2};
        vecs[7]  = '{128, 0, 10, 10, 120, 0, 2};
        vecs[8]  = '{129, 0, 10,  0,   0, 1, 0};
        vecs[9]  = '{142, 0, 10,  8, 150, 0, 2};
        vecs[10] = '{112, 0, 10, 10, 120, 0, 2};

        rst = 1'b1;
        bus.en = 1'b0;
        bus.env_high = 1'b0;
        cyc(4);
        chk_outs("reset", 0, 0, 0);
        chk("reset.sync", 32'(bus.sync_pulse), 0);
        chk("reset.err",  32'(bus.err_pulse),  0);
        rst = 1'b0;
        cyc(2);

        // Table-driven rate classification and boundaries
        for (int v = 0; v < 11; v++) begin
            restart();
            runs_q.delete();
            for (int i = 0; i < vecs[v].nruns; i++)
                runs_q.push_back(vecs[v].pat != 0 ? vecs[v].base * (i % 3 + 1) : vecs[v].base);
            run_and_check($sformatf("vec%0d", v), (vecs[v].rate != 0) ? 1 : 0,
                          vecs[v].rate, vecs[v].spb, vecs[v].errs, vecs[v].syncs);
        end

        // Randomized run sequences against the run-level model
        for (int t = 0; t < 5; t++) begin
            int kind;
            int n;
            int base;
            restart();
            runs_q.delete();
            kind = int'($urandom_range(0, 3));
            n = int'($urandom_range(10, 15));
            base = (kind == 0) ? P10 : (kind == 1) ? P8 : P6;
            for (int i = 0; i < n; i++) begin
                if (kind == 3)
                    runs_q.push_back(int'($urandom_range(60, 400)));
                else
                    runs_q.push_back(base * ((i == 0) ? 1 : int'($urandom_range(1, 3)))
                                     + int'($urandom_range(0, 8)) - 4);
            end
            model(m_lk, m_rate, m_spb, m_errs, m_syncs);
            run_and_check($sformatf("rnd%0d", t), m_lk, m_rate, m_spb, m_errs, m_syncs);
        end

        // Lock at 8 kbps, then signal loss
        restart();
        fill_square(P8, 10);
        run_and_check("lock8", 1, 8, P8, 0, 2);
        cyc(PLOSS - 40);
        chk("loss.before", 32'(bus.locked), 1);
        cyc(60);
        chk_outs("loss.after", 0, 0, P8);

        // Five measured edges in ACQ, then en drop clears everything
        fill_square(P8, 5);
        play_runs();
        cyc(8);
        chk_outs("acq5", 0, 0, P8);
        bus.en = 1'b0;
        cyc(2);
        chk_outs("en_drop", 0, 0, 0);
        bus.en = 1'b1;
        cyc(4);
        fill_square(P8, 7);
        play_runs();
        cyc(8);
        chk("reacq.7runs", 32'(bus.locked), 0);
        cyc(P8 - 8);
        toggle();
        cyc(8);
        chk_outs("reacq.8runs", 1, 8, P8);

        // Single-cycle spike mid-run while locked at 6 kbps
        restart();
        fill_square(P6, 10);
        run_and_check("lock6", 1, 6, P6, 0, 2);
        s0 = sync_total;
        cyc(50);
        toggle();
        cyc(1);
        toggle();
        cyc(149);
        toggle();
        cyc(8);
        chk("spike.syncs", 32'(sync_total - s0), 1);
        chk_outs("spike", 1, 6, P6);

        // rst wins over en while locked
        rst = 1'b1;
        cyc(2);
        chk_outs("rst_locked", 0, 0, 0);
        rst = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
